// File: rtl/mem_bus_pkg.sv
// Shared definitions for the asynchronous-SRAM bus responder.
// - Default address/data widths and the byte-enable width derived from them.
// - Read FSM state encoding and the per-cycle access classification.
// - decode_access(): classifies one bus cycle from the active-low strobes.
package mem_bus_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned BE_W_DEF   = DATA_W_DEF / 8;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRIVE = 2'd2
  } rd_state_e;

  typedef enum logic [1:0] {
    ACC_IDLE = 2'd0,
    ACC_RD   = 2'd1,
    ACC_WR   = 2'd2
  } acc_kind_e;

  // A write wins whenever we_n is low, so oe_n is only looked at for reads.
  function automatic acc_kind_e decode_access(input logic ce_n, input logic oe_n,
                                              input logic we_n);
    if (!ce_n && !we_n) return ACC_WR;
    if (!ce_n && !oe_n) return ACC_RD;
    return ACC_IDLE;
  endfunction

endpackage

// File: rtl/sram_byte_array.sv
// DEPTH x DATA_W storage with per-byte-lane write enables and an asynchronous read port.
// Contents are never reset.
// Ports:
// - clk      in  clock for the write port
// - wr_en    in  write this edge
// - lane_en  in  active-high lane enables, lane i = bits [8i+7:8i]
// - wr_idx   in  write word index
// - wr_data  in  write data
// - rd_idx   in  read word index
// - rd_data  out combinational read data
module sram_byte_array #(
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned DATA_W = 32,
  localparam int unsigned BE_W  = DATA_W / 8,
  localparam int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [BE_W-1:0]   lane_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (lane_en[i]) mem_q[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  assign rd_data = mem_q[rd_idx];

endmodule

// File: rtl/sram_bus_responder.sv
// Device-side responder for the BaseRAM/ExtRAM asynchronous-SRAM bus.
// Acts as a 32-bit SRAM: byte-lane writes, full-word reads driven onto the shared bus after a
// programmable latency, a sticky contention flag and read/write access counters.
// Ports:
// - clk, rst        clock; asynchronous active-high reset
// - ram_data        shared data bus, driven only while presenting read data
// - ram_addr        word address (low log2(DEPTH) bits index the array, the rest alias)
// - ram_be_n        active-low byte enables
// - ram_ce_n/oe_n/we_n  active-low chip select, output enable, write enable
// - err_contention  sticky: a write cycle saw oe_n low as well
// - rd_count        completed reads, wraps
// - wr_count        write accesses, wraps
module sram_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned DEPTH  = 4096,
  parameter int unsigned RD_LAT = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  inout  wire logic [DATA_W-1:0] ram_data,
  input  logic [ADDR_W-1:0]     ram_addr,
  input  logic [DATA_W/8-1:0]   ram_be_n,
  input  logic                  ram_ce_n,
  input  logic                  ram_oe_n,
  input  logic                  ram_we_n,
  output logic                  err_contention,
  output logic [31:0]           rd_count,
  output logic [31:0]           wr_count
);

  localparam int unsigned IDX_W = $clog2(DEPTH);

  acc_kind_e         acc;
  logic              is_wr;
  logic              is_rd;
  logic              contention;
  logic [DATA_W-1:0] rd_data;
  logic              rd_drive;
  logic              rd_inc;
  logic              bus_drive;

  always_comb begin
    acc        = decode_access(ram_ce_n, ram_oe_n, ram_we_n);
    is_wr      = (acc == ACC_WR);
    is_rd      = (acc == ACC_RD);
    contention = is_wr & ~ram_oe_n;
  end

  sram_byte_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .wr_en   (is_wr),
    .lane_en (~ram_be_n),
    .wr_idx  (ram_addr[IDX_W-1:0]),
    .wr_data (ram_data),
    .rd_idx  (ram_addr[IDX_W-1:0]),
    .rd_data (rd_data)
  );

  // Write accounting: one count per access, where a new address inside a held WR is a new access.
  logic              wr_act_q, wr_act_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_count_q, wr_count_d;
  logic [31:0]       rd_count_q, rd_count_d;
  logic              err_q, err_d;

  always_comb begin
    wr_act_d   = is_wr;
    wr_addr_d  = is_wr ? ram_addr : wr_addr_q;
    wr_count_d = wr_count_q;
    if (is_wr && (!wr_act_q || (ram_addr != wr_addr_q))) wr_count_d = wr_count_q + 32'd1;
    rd_count_d = rd_inc ? rd_count_q + 32'd1 : rd_count_q;
    err_d      = err_q | contention;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_act_q   <= 1'b0;
      wr_addr_q  <= '0;
      wr_count_q <= '0;
      rd_count_q <= '0;
      err_q      <= 1'b0;
    end else begin
      wr_act_q   <= wr_act_d;
      wr_addr_q  <= wr_addr_d;
      wr_count_q <= wr_count_d;
      rd_count_q <= rd_count_d;
      err_q      <= err_d;
    end
  end

  if (RD_LAT == 0) begin : g_async_rd
    logic              rd_act_q, rd_act_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

    always_comb begin
      rd_act_d  = is_rd;
      rd_addr_d = is_rd ? ram_addr : rd_addr_q;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rd_act_q  <= 1'b0;
        rd_addr_q <= '0;
      end else begin
        rd_act_q  <= rd_act_d;
        rd_addr_q <= rd_addr_d;
      end
    end

    assign rd_drive = is_rd;
    assign rd_inc   = is_rd & (~rd_act_q | (ram_addr != rd_addr_q));
  end else begin : g_lat_rd
    localparam logic [1:0] LAT_RELOAD = 2'(RD_LAT - 1);

    rd_state_e         state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;

    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      raddr_d = raddr_q;
      rd_inc  = 1'b0;
      if (!is_rd) begin
        state_d = S_IDLE;
      end else if ((state_q == S_IDLE) || (ram_addr != raddr_q)) begin
        // New read, or the address moved under a pending/active one: restart the wait.
        state_d = S_WAIT;
        cnt_d   = LAT_RELOAD;
        raddr_d = ram_addr;
      end else if (state_q == S_WAIT) begin
        if (cnt_q == 2'd0) begin
          state_d = S_DRIVE;
          rd_inc  = 1'b1;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end else if (state_q != S_DRIVE) begin
        state_d = S_IDLE;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= S_IDLE;
        cnt_q   <= 2'd0;
        raddr_q <= '0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        raddr_q <= raddr_d;
      end
    end

    // The address compare releases the bus in the same cycle the address moves.
    assign rd_drive = (state_q == S_DRIVE) && is_rd && (ram_addr == raddr_q);
  end

  // Reset and we_n both gate the driver combinationally so the bus is freed without a clock.
  assign bus_drive = rd_drive & ~rst;
  assign ram_data  = bus_drive ? rd_data : {DATA_W{1'bz}};

  assign err_contention = err_q;
  assign rd_count       = rd_count_q;
  assign wr_count       = wr_count_q;

endmodule

// File: tb/tb_sram_bus_responder.sv
module tb_sram_bus_responder;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned LAT   = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  wire  [31:0] bus0;
  wire  [31:0] bus2;
  logic        tb_drv;
  logic [31:0] tb_wdata;
  assign bus0 = tb_drv ? tb_wdata : 32'hzzzz_zzzz;
  assign bus2 = tb_drv ? tb_wdata : 32'hzzzz_zzzz;

  logic [19:0] addr;
  logic [3:0]  be_n;
  logic        ce_n, oe_n, we_n;
  logic        err0, err2;
  logic [31:0] rdc0, wrc0, rdc2, wrc2;

  sram_bus_responder #(.ADDR_W(20), .DATA_W(32), .DEPTH(DEPTH), .RD_LAT(0)) u_dut0 (
    .clk(clk), .rst(rst), .ram_data(bus0), .ram_addr(addr), .ram_be_n(be_n),
    .ram_ce_n(ce_n), .ram_oe_n(oe_n), .ram_we_n(we_n),
    .err_contention(err0), .rd_count(rdc0), .wr_count(wrc0)
  );

  sram_bus_responder #(.ADDR_W(20), .DATA_W(32), .DEPTH(DEPTH), .RD_LAT(LAT)) u_dut2 (
    .clk(clk), .rst(rst), .ram_data(bus2), .ram_addr(addr), .ram_be_n(be_n),
    .ram_ce_n(ce_n), .ram_oe_n(oe_n), .ram_we_n(we_n),
    .err_contention(err2), .rd_count(rdc2), .wr_count(wrc2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;
  exp_t q0[$];
  exp_t q2[$];

  // Reference model: memory image with per-lane "ever written" flags, run lengths, counters.
  logic [31:0] mdl_mem   [DEPTH];
  logic [3:0]  mdl_known [DEPTH];
  int          rd_run;
  logic [19:0] rd_run_addr;
  bit          wr_prev;
  logic [19:0] wr_prev_addr;
  logic [31:0] m_rd [2];
  logic [31:0] m_wr [2];
  logic        m_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] k);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
    return m;
  endfunction

  task automatic model_reset();
    rd_run = 0;
    wr_prev = 0;
    wr_prev_addr = '0;
    rd_run_addr = '0;
    m_rd[0] = '0; m_rd[1] = '0;
    m_wr[0] = '0; m_wr[1] = '0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input logic c, input logic o, input logic w, input logic [3:0] b,
                            input logic [19:0] a, input logic [31:0] d);
    bit   wr, rd;
    int   idx;
    exp_t e;
    wr  = !c && !w;
    rd  = !c && !o && w;
    idx = int'(a) % DEPTH;
    if (rd) begin
      if (rd_run > 0 && a == rd_run_addr) rd_run++;
      else begin
        rd_run = 1;
        rd_run_addr = a;
      end
      e.cyc  = cyc;
      e.data = mdl_mem[idx];
      e.mask = lane_mask(mdl_known[idx]);
      q0.push_back(e);
      // Latency: one edge to enter the wait, LAT more to reach the drive state.
      if (rd_run >= LAT + 2) q2.push_back(e);
      if (rd_run == 1) m_rd[0] = m_rd[0] + 1;
      if (rd_run == LAT + 1) m_rd[1] = m_rd[1] + 1;
    end else begin
      rd_run = 0;
    end
    if (wr) begin
      if (!wr_prev || a != wr_prev_addr) begin
        m_wr[0] = m_wr[0] + 1;
        m_wr[1] = m_wr[1] + 1;
      end
      for (int i = 0; i < 4; i++) begin
        if (!b[i]) begin
          mdl_mem[idx][8*i +: 8] = d[8*i +: 8];
          mdl_known[idx][i] = 1'b1;
        end
      end
      if (!o) m_err = 1'b1;
    end
    wr_prev = wr;
    wr_prev_addr = a;
  endtask

  task automatic bus_cycle(input logic c, input logic o, input logic w, input logic [3:0] b,
                           input logic [19:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    check("rd_count L0", rdc0, m_rd[0]);
    check("rd_count L2", rdc2, m_rd[1]);
    check("wr_count L0", wrc0, m_wr[0]);
    check("wr_count L2", wrc2, m_wr[1]);
    check("err_contention L0", {31'd0, err0}, {31'd0, m_err});
    check("err_contention L2", {31'd0, err2}, {31'd0, m_err});
    ce_n = c; oe_n = o; we_n = w; be_n = b; addr = a;
    tb_drv = !c && !w;
    tb_wdata = d;
    cyc++;
    model_step(c, o, w, b, a, d);
  endtask

  task automatic wr_op(input logic [19:0] a, input logic [31:0] d, input logic [3:0] b);
    bus_cycle(1'b0, 1'b1, 1'b0, b, a, d);
  endtask

  task automatic rd_op(input logic [19:0] a);
    bus_cycle(1'b0, 1'b0, 1'b1, 4'b0000, a, $urandom());
  endtask

  task automatic idle_op();
    bus_cycle(1'b1, 1'b1, 1'b1, 4'b1111, 20'h0, 32'h0);
  endtask

  // Scoreboard: flush stale expectations, then match a presented drive to the queue head.
  task automatic sb_step(input int w, input logic drv, input logic [31:0] bus);
    exp_t e;
    int   sz;
    while (1) begin
      sz = (w == 0) ? q0.size() : q2.size();
      if (sz == 0) break;
      e = (w == 0) ? q0[0] : q2[0];
      if (e.cyc >= cyc) break;
      n_checks++;
      n_fail++;
      $display("FAIL read drive L%0d missing: cycle %0d not driven, required %h", w, e.cyc, e.data);
      if (w == 0) void'(q0.pop_front());
      else void'(q2.pop_front());
    end
    if (drv) begin
      sz = (w == 0) ? q0.size() : q2.size();
      if (sz == 0 || ((w == 0) ? q0[0].cyc : q2[0].cyc) != cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL bus drive L%0d unexpected: cycle %0d driven %h, required Z", w, cyc, bus);
      end else begin
        e = (w == 0) ? q0.pop_front() : q2.pop_front();
        check((w == 0) ? "read data L0" : "read data L2", bus & e.mask, e.data & e.mask);
      end
    end
  endtask

  always @(negedge clk) if (!rst) sb_step(0, u_dut0.bus_drive, bus0);
  always @(negedge clk) if (!rst) sb_step(2, u_dut2.bus_drive, bus2);

  function automatic logic [19:0] pick_addr();
    logic [19:0] r;
    r = 20'($urandom());
    case ($urandom_range(0, 7))
      0: return 20'h00005;
      1: return 20'h01005;
      2: return 20'h00010;
      3: return 20'h00020;
      4: return 20'h00021;
      5: return 20'h80020;
      6: return {12'h000, r[7:0]};
      default: return r;
    endcase
  endfunction

  initial begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      mdl_mem[i] = '0;
      mdl_known[i] = '0;
    end
    model_reset();
    rst = 1'b1;
    ce_n = 1'b1; oe_n = 1'b1; we_n = 1'b1; be_n = 4'hF; addr = '0;
    tb_drv = 1'b0; tb_wdata = '0;
    #2;
    check("reset rd_count", rdc0 | rdc2, 32'd0);
    check("reset wr_count", wrc0 | wrc2, 32'd0);
    check("reset err", {31'd0, err0 | err2}, 32'd0);
    check("reset drive", {31'd0, u_dut0.bus_drive | u_dut2.bus_drive}, 32'd0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b0;

    // Basic write then same-cycle asynchronous read.
    wr_op(20'h00010, 32'hDEAD_BEEF, 4'b0000);
    rd_op(20'h00010);
    #1 check("async read", bus0, 32'hDEAD_BEEF);
    idle_op();
    check("wr_count after one write", wrc0, 32'd1);
    check("rd_count after one read", rdc0, 32'd1);

    // Byte lanes.
    wr_op(20'h00030, 32'h1122_3344, 4'b0000);
    wr_op(20'h00030, 32'hAABB_CCDD, 4'b1101);
    rd_op(20'h00030);
    #1 check("lane merge", bus0, 32'h1122_CC44);
    wr_op(20'h00030, 32'hFFFF_FFFF, 4'b1111);
    rd_op(20'h00030);
    #1 check("no-lane write", bus0, 32'h1122_CC44);

    // Latency with RD_LAT=2, then an address change while waiting.
    wr_op(20'h00020, 32'hCAFE_F00D, 4'b0000);
    wr_op(20'h00021, 32'h2121_2121, 4'b0000);
    for (int i = 0; i < 6; i++) begin
      rd_op(20'h00020);
      #1 check("L2 drive timing", {31'd0, u_dut2.bus_drive}, {31'd0, (i >= 3)});
      if (i >= 3) check("L2 data", bus2, 32'hCAFE_F00D);
    end
    idle_op();
    for (int i = 0; i < 2; i++) rd_op(20'h00020);
    for (int i = 0; i < 5; i++) begin
      rd_op(20'h00021);
      #1 check("L2 restart timing", {31'd0, u_dut2.bus_drive}, {31'd0, (i >= 3)});
    end
    idle_op();

    // Contention: write wins, bus never driven, flag sticks.
    bus_cycle(1'b0, 1'b0, 1'b0, 4'b0000, 20'h00040, 32'h5A5A_5A5A);
    #1 check("contention drive", {31'd0, u_dut0.bus_drive | u_dut2.bus_drive}, 32'd0);
    idle_op();
    idle_op();
    check("err sticky", {31'd0, err0 & err2}, 32'd1);
    rd_op(20'h00040);
    #1 check("contention write data", bus0, 32'h5A5A_5A5A);

    // Aliasing above DEPTH.
    wr_op(20'h01005, 32'h0BAD_C0DE, 4'b0000);
    rd_op(20'h00005);
    #1 check("alias read", bus0, 32'h0BAD_C0DE);

    // Reset while the latency responder is driving.
    for (int i = 0; i < 5; i++) rd_op(20'h00020);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    check("reset-mid drive", {31'd0, u_dut0.bus_drive | u_dut2.bus_drive}, 32'd0);
    check("reset-mid counts", rdc0 | rdc2 | wrc0 | wrc2, 32'd0);
    check("reset-mid err", {31'd0, err0 | err2}, 32'd0);
    ce_n = 1'b1;
    tb_drv = 1'b0;
    @(negedge clk);
    #1 rst = 1'b0;
    model_reset();
    for (int i = 0; i < 5; i++) rd_op(20'h00020);
    #1 check("memory kept over reset", bus2, 32'hCAFE_F00D);

    // Write counter wrap.
    idle_op();
    force u_dut0.wr_count_q = 32'hFFFF_FFFF;
    #1 release u_dut0.wr_count_q;
    m_wr[0] = 32'hFFFF_FFFF;
    wr_op(20'h00050, 32'h1234_5678, 4'b0000);
    idle_op();
    check("wr_count wrap", wrc0, 32'd0);

    // Randomized accesses.
    for (int n = 0; n < 250; n++) begin
      int          kind;
      int          len;
      logic [19:0] a;
      kind = int'($urandom_range(0, 11));
      len  = int'($urandom_range(1, 7));
      a    = pick_addr();
      for (int k = 0; k < len; k++) begin
        if ($urandom_range(0, 5) == 0) a = pick_addr();
        case (kind)
          0:          idle_op();
          1:          bus_cycle(1'b0, 1'b1, 1'b1, 4'($urandom()), a, $urandom());
          2:          bus_cycle(1'b1, 1'b0, 1'b0, 4'($urandom()), a, $urandom());
          3, 4, 5, 6: rd_op(a);
          7, 8, 9:    wr_op(a, $urandom(), 4'($urandom()));
          10:         wr_op(a, $urandom(), 4'b0000);
          default:    bus_cycle(1'b0, 1'b0, 1'b0, 4'($urandom()), a, $urandom());
        endcase
      end
    end

    repeat (6) idle_op();
    check("scoreboard L0 drained", q0.size(), 32'd0);
    check("scoreboard L2 drained", q2.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
